// File: rtl/tail_light_sequencer.sv
// tail_light_sequencer: timed LED tail-light patterns from a 2-bit light-mode code.
module tail_light_sequencer #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] current_state,
  output logic [9:0] LEDR,
  output logic [1:0] seq_step,
  output logic       tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} mode_e;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q, cmd_q;
  mode_e         mode_q, mode_d;
  logic [1:0]    phase_q, phase_d;
  assign tick = cnt_q == LAST;
  always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      sync_q  <= '0;
      cmd_q   <= '0;
      mode_q  <= IDLE;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sync_q  <= current_state;
      cmd_q   <= sync_q;
      mode_q  <= mode_d;
      phase_q <= phase_d;
    end
  end
  // A mode change always restarts the pattern, even mid-sweep at phase 3.
  always_comb begin
    mode_d  = tick ? mode_e'(cmd_q) : mode_q;
    phase_d = !tick ? phase_q : (cmd_q != mode_q || mode_q == IDLE) ? 2'd0 : phase_q + 2'd1;
  end
  always_comb begin
    LEDR = '0;
    case (mode_q)
      LEFT:    LEDR = phase_q == 2'd1 ? 10'h080 : phase_q == 2'd2 ? 10'h180 : phase_q == 2'd3 ? 10'h380 : 10'h000;
      RIGHT:   LEDR = phase_q == 2'd1 ? 10'h004 : phase_q == 2'd2 ? 10'h006 : phase_q == 2'd3 ? 10'h007 : 10'h000;
      HAZARD:  LEDR = phase_q[0] ? 10'h387 : 10'h000;
      default: LEDR = '0;
    endcase
    seq_step = phase_q;
  end
endmodule

// File: tb/tb_tail_light_sequencer.sv
// tb_tail_light_sequencer: directed vector table plus hand sequences, TICK_DIV=4.
module tb_tail_light_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] current_state = 2'd0;
  logic [9:0] LEDR;
  logic [1:0] seq_step;
  logic       tick;
  int passed = 0;
  int total = 0;

  tail_light_sequencer #(.TICK_DIV(4)) dut (
    .clock(clock), .reset(reset), .current_state(current_state),
    .LEDR(LEDR), .seq_step(seq_step), .tick(tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] cs;
    logic [9:0] led;
    logic [1:0] step;
  } vec_t;
  vec_t vecs[18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advances to just after the next tick edge; n counts edges taken, pre_led is LEDR seen while tick was high.
  task automatic wait_tick(output int n, output logic [9:0] pre_led);
    n = 0;
    while (!tick && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (!tick) begin
      $display("FAIL tick_timeout: got no tick expected tick within 20 cycles");
      total++;
    end
    pre_led = LEDR;
    @(posedge clock); #1;
    n++;
  endtask

  task automatic step_chk(input string name, input logic [9:0] led, input logic [1:0] step);
    int n;
    logic [9:0] pre;
    wait_tick(n, pre);
    chk({name, "_period"}, 16'(n), 16'd4);
    chk({name, "_led"}, 16'(LEDR), 16'(led));
    chk({name, "_step"}, 16'(seq_step), 16'(step));
  endtask

  initial begin
    int n;
    logic [9:0] pre;
    vecs[0]  = '{2'd1, 10'h000, 2'd0};
    vecs[1]  = '{2'd1, 10'h080, 2'd1};
    vecs[2]  = '{2'd1, 10'h180, 2'd2};
    vecs[3]  = '{2'd1, 10'h380, 2'd3};
    vecs[4]  = '{2'd1, 10'h000, 2'd0};
    vecs[5]  = '{2'd1, 10'h080, 2'd1};
    vecs[6]  = '{2'd0, 10'h000, 2'd0};
    vecs[7]  = '{2'd0, 10'h000, 2'd0};
    vecs[8]  = '{2'd2, 10'h000, 2'd0};
    vecs[9]  = '{2'd2, 10'h004, 2'd1};
    vecs[10] = '{2'd2, 10'h006, 2'd2};
    vecs[11] = '{2'd2, 10'h007, 2'd3};
    vecs[12] = '{2'd2, 10'h000, 2'd0};
    vecs[13] = '{2'd3, 10'h000, 2'd0};
    vecs[14] = '{2'd3, 10'h387, 2'd1};
    vecs[15] = '{2'd3, 10'h000, 2'd2};
    vecs[16] = '{2'd3, 10'h387, 2'd3};
    vecs[17] = '{2'd3, 10'h000, 2'd0};

    current_state = 2'd1;
    #22;
    chk("rst_led", 16'(LEDR), 16'h000);
    chk("rst_step", 16'(seq_step), 16'd0);
    chk("rst_tick", 16'(tick), 16'd0);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    while (!tick && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("first_tick_edges", 16'(n), 16'd3);

    for (int i = 0; i < 18; i++) begin
      current_state = vecs[i].cs;
      wait_tick(n, pre);
      if (i > 0) begin
        chk($sformatf("vec%0d_period", i), 16'(n), 16'd4);
        chk($sformatf("vec%0d_hold", i), 16'(pre), 16'(vecs[i-1].led));
      end
      chk($sformatf("vec%0d_led", i), 16'(LEDR), 16'(vecs[i].led));
      chk($sformatf("vec%0d_step", i), 16'(seq_step), 16'(vecs[i].step));
    end

    current_state = 2'd1;
    step_chk("mid_l0", 10'h000, 2'd0);
    step_chk("mid_l1", 10'h080, 2'd1);
    step_chk("mid_l2", 10'h180, 2'd2);
    current_state = 2'd2;
    step_chk("mid_r0", 10'h000, 2'd0);
    step_chk("mid_r1", 10'h004, 2'd1);

    repeat (2) @(posedge clock);
    #1 current_state = 2'd3;
    repeat (2) @(posedge clock);
    #1 current_state = 2'd2;
    chk("glitch_t4_led", 16'(LEDR), 16'h006);
    chk("glitch_t4_step", 16'(seq_step), 16'd2);
    step_chk("glitch_t8", 10'h007, 2'd3);
    current_state = 2'd1;
    step_chk("ph3_switch", 10'h000, 2'd0);

    step_chk("idle_l1", 10'h080, 2'd1);
    step_chk("idle_l2", 10'h180, 2'd2);
    step_chk("idle_l3", 10'h380, 2'd3);
    current_state = 2'd0;
    step_chk("idle_a", 10'h000, 2'd0);
    step_chk("idle_b", 10'h000, 2'd0);
    step_chk("idle_c", 10'h000, 2'd0);

    current_state = 2'd3;
    step_chk("haz_0", 10'h000, 2'd0);
    step_chk("haz_1", 10'h387, 2'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("pre_rst_tick", 16'(tick), 16'd1);
    chk("pre_rst_led", 16'(LEDR), 16'h387);
    #3 reset = 1'b0;
    #1;
    chk("async_led", 16'(LEDR), 16'h000);
    chk("async_step", 16'(seq_step), 16'd0);
    chk("async_tick", 16'(tick), 16'd0);
    repeat (2) @(posedge clock);
    #1 chk("held_rst_led", 16'(LEDR), 16'h000);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    while (!tick && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("rerst_tick_edges", 16'(n), 16'd3);
    chk("rerst_led_before", 16'(LEDR), 16'h000);
    wait_tick(n, pre);
    chk("rerst_mode_led", 16'(LEDR), 16'h000);
    chk("rerst_mode_step", 16'(seq_step), 16'd0);
    step_chk("rerst_haz1", 10'h387, 2'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
